servo_seq_ctrl: RTL

SERVO_SEQ_CTRL -- requirements
Module: servo_seq_ctrl

---
 rtl/servo_pkg.sv | 35 +++
 rtl/servo_pwm_gen.sv | 50 +++++
 rtl/servo_seq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared widths, default servo timing and the sequencer state type for the
// servo sequencer slice.
package servo_pkg;

    localparam int PW_W     = 20;
    localparam int DIFF_W   = PW_W + 1;
    localparam int SETTLE_W = 8;

    localparam int DEF_FRAME_CYCLES  = 481000;
    localparam int DEF_MIN_PW        = 11200;
    localparam int DEF_MID_PW        = 40350;
    localparam int DEF_MAX_PW        = 69500;
    localparam int DEF_STEP_PW       = 292;
    localparam int DEF_SETTLE_FRAMES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SETTLE
    } servo_state_t;

    function automatic logic [PW_W-1:0] clampPw(input logic [PW_W-1:0] pw,
                                                input logic [PW_W-1:0] lo,
                                                input logic [PW_W-1:0] hi);
        logic [PW_W-1:0] result;
        result = pw;
        if (pw < lo) begin
            result = lo;
        end else if (pw > hi) begin
            result = hi;
        end
        return result;
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Frame counter and registered pulse generator. The compare uses the pulse
// width that will be current after this edge, so pwm rises with frame_start.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [PW_W-1:0] i_pw_next,
    output logic            o_run,
    output logic            o_wrap,
    output logic            o_frame_start,
    output logic            o_pwm
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_run;
    logic             r_pwm;

    // The counter stays parked at 0 until the first edge after reset release.
    always_comb begin
        w_cnt_next = '0;
        if (r_run && (r_cnt != LAST_CNT)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_cnt <= w_cnt_next;
            r_pwm <= (32'(w_cnt_next) < 32'(i_pw_next));
        end
    end

    assign o_run         = r_run;
    assign o_wrap        = r_run && (r_cnt == LAST_CNT);
    assign o_frame_start = r_run && (r_cnt == '0);
    assign o_pwm         = r_pwm;

endmodule

// File: rtl/servo_seq_ctrl.sv
// Servo command sequencer: accepts a target pulse width, slews the applied
// width toward it once per frame, then holds for a settle period.
module servo_seq_ctrl
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES  = DEF_FRAME_CYCLES,
    parameter int MIN_PW        = DEF_MIN_PW,
    parameter int MID_PW        = DEF_MID_PW,
    parameter int MAX_PW        = DEF_MAX_PW,
    parameter int STEP_PW       = DEF_STEP_PW,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_cmd_valid,
    input  logic [PW_W-1:0] i_cmd_pw,
    output logic            o_cmd_ready,
    output logic            o_cmd_clamped,
    output logic            o_busy,
    output logic [PW_W-1:0] o_cur_pw,
    output logic            o_frame_start,
    output logic            o_pwm
);

    localparam logic [PW_W-1:0]            MIN_V      = PW_W'(MIN_PW);
    localparam logic [PW_W-1:0]            MID_V      = PW_W'(MID_PW);
    localparam logic [PW_W-1:0]            MAX_V      = PW_W'(MAX_PW);
    localparam logic [PW_W-1:0]            STEP_V     = PW_W'(STEP_PW);
    localparam logic signed [DIFF_W-1:0]   STEP_S     = DIFF_W'(STEP_PW);
    localparam logic [SETTLE_W-1:0]        SETTLE_LIM = SETTLE_W'(SETTLE_FRAMES);

    servo_state_t r_state;
    servo_state_t w_state_next;
    logic [PW_W-1:0]     r_target;
    logic [PW_W-1:0]     w_target_next;
    logic [PW_W-1:0]     r_cur_pw;
    logic [PW_W-1:0]     w_cur_pw_next;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [SETTLE_W-1:0] w_settle_next;
    logic [SETTLE_W-1:0] w_settle_inc;
    logic                r_clamped;
    logic                w_clamped_next;
    logic signed [DIFF_W-1:0] w_diff;

    logic w_run;
    logic w_wrap;
    logic w_frame_start;
    logic w_pwm;
    logic w_handshake;

    assign o_cmd_ready = w_run && (r_state == ST_IDLE);
    assign w_handshake = i_cmd_valid && o_cmd_ready;
    assign w_diff      = $signed({1'b0, r_target}) - $signed({1'b0, r_cur_pw});
    assign w_settle_inc = r_settle_cnt + SETTLE_W'(1);

    // Motion is evaluated only on the wrap edge, so a command accepted on the
    // wrap cycle cannot move cur_pw until the following wrap.
    always_comb begin
        w_state_next   = r_state;
        w_target_next  = r_target;
        w_cur_pw_next  = r_cur_pw;
        w_settle_next  = r_settle_cnt;
        w_clamped_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_target_next  = clampPw(i_cmd_pw, MIN_V, MAX_V);
                    w_clamped_next = (i_cmd_pw < MIN_V) || (i_cmd_pw > MAX_V);
                    w_state_next   = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (w_wrap) begin
                    if (w_diff == '0) begin
                        w_state_next  = ST_SETTLE;
                        w_settle_next = '0;
                    end else if (w_diff > STEP_S) begin
                        w_cur_pw_next = r_cur_pw + STEP_V;
                    end else if (w_diff < -STEP_S) begin
                        w_cur_pw_next = r_cur_pw - STEP_V;
                    end else begin
                        w_cur_pw_next = r_target;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_wrap) begin
                    w_settle_next = w_settle_inc;
                    if (w_settle_inc >= SETTLE_LIM) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_target     <= MID_V;
            r_cur_pw     <= MID_V;
            r_settle_cnt <= '0;
            r_clamped    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_target     <= w_target_next;
            r_cur_pw     <= w_cur_pw_next;
            r_settle_cnt <= w_settle_next;
            r_clamped    <= w_clamped_next;
        end
    end

    servo_pwm_gen #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_pwm_gen (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pw_next     (w_cur_pw_next),
        .o_run         (w_run),
        .o_wrap        (w_wrap),
        .o_frame_start (w_frame_start),
        .o_pwm         (w_pwm)
    );

    assign o_cmd_clamped = r_clamped;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_cur_pw      = r_cur_pw;
    assign o_frame_start = w_frame_start;
    assign o_pwm         = w_pwm;

endmodule
